// File: rtl/uart_core.sv
// UART transceiver: TX/RX FIFOs with oversampled TX and RX state machines,
// run-time parity and stop-bit selection, and internal loopback.
module uart_core #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned OVS        = 16,
   localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [15:0]       div_i,
   input  logic [1:0]        parity_i,
   input  logic              stop2_i,
   input  logic              loop_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_perr_o,
   output logic              rx_ferr_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              rx_ovf_o,
   input  logic              ovf_clr_i,
   output logic              tx_busy_o,
   output logic [LW-1:0]     tx_level_o,
   output logic [LW-1:0]     rx_level_o,
   output logic              tx_o,
   input  logic              rx_i
);
   localparam int unsigned AW = LW - 1;
   localparam int unsigned OW = $clog2(OVS);
   localparam int unsigned BW = $clog2(DATA_W);
   localparam int unsigned EW = DATA_W + 2;
   localparam logic [LW-1:0] Full    = LW'(FIFO_DEPTH);
   localparam logic [OW-1:0] OvsLast = OW'(OVS - 1);
   localparam logic [OW-1:0] OvsMid  = OW'(OVS / 2 - 1);
   localparam logic [BW-1:0] BitLast = BW'(DATA_W - 1);

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop, RxWait} rx_state_e;

   logic [15:0]       pre_q, div_q;
   logic              tick;
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [LW-1:0]     tx_wp_q, tx_rp_q;
   logic              tx_wr, tx_pop, tx_line, tx_bit_end;
   logic [DATA_W-1:0] tx_head, tx_sh_q;
   tx_state_e         tx_st_q, tx_st_d;
   logic [OW-1:0]     tx_cnt_q;
   logic [BW-1:0]     tx_bit_q;
   logic              tx_par_q, tx_pen_q, tx_stop2_q;
   logic [EW-1:0]     rx_mem [FIFO_DEPTH];
   logic [LW-1:0]     rx_wp_q, rx_rp_q;
   logic              rx_push, rx_pop, rx_full, rx_wr, rx_ovf_q;
   logic [EW-1:0]     rx_head;
   logic              rx_in, rx_s1_q, rx_s_q, rx_prev_q, rx_fall, rx_bit_end, rx_perr_q;
   rx_state_e         rx_st_q, rx_st_d;
   logic [OW-1:0]     rx_cnt_q;
   logic [BW-1:0]     rx_bit_q;
   logic [DATA_W-1:0] rx_sh_q;

   // Divisor is captured on each wrap so a change only takes effect at the next one.
   assign tick = (pre_q == div_q);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q <= '0;
         div_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
         div_q <= div_i;
      end else begin
         pre_q <= pre_q + 16'd1;
      end
   end

   assign tx_level_o = tx_wp_q - tx_rp_q;
   assign tx_ready_o = (tx_level_o != Full);
   assign tx_wr      = tx_valid_i && tx_ready_o;
   assign tx_head    = tx_mem[tx_rp_q[AW-1:0]];
   assign tx_busy_o  = (tx_st_q != TxIdle) || (tx_level_o != '0);

   always_ff @(posedge clk_i) begin
      if (tx_wr) tx_mem[tx_wp_q[AW-1:0]] <= tx_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_wp_q <= '0;
         tx_rp_q <= '0;
      end else begin
         if (tx_wr)  tx_wp_q <= tx_wp_q + LW'(1);
         if (tx_pop) tx_rp_q <= tx_rp_q + LW'(1);
      end
   end

   assign tx_bit_end = tick && (tx_cnt_q == OvsLast);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tx_st_q <= TxIdle;
      else       tx_st_q <= tx_st_d;
   end

   // STOP chains straight into START when more data is queued, so frames abut.
   always_comb begin
      tx_st_d = tx_st_q;
      case (tx_st_q)
         TxIdle:  if (tick && tx_level_o != '0) tx_st_d = TxStart;
         TxStart: if (tx_bit_end) tx_st_d = TxData;
         TxData:  if (tx_bit_end && tx_bit_q == BitLast) tx_st_d = tx_pen_q ? TxPar : TxStop;
         TxPar:   if (tx_bit_end) tx_st_d = TxStop;
         TxStop:  if (tx_bit_end && (!tx_stop2_q || tx_bit_q != '0))
                     tx_st_d = (tx_level_o != '0) ? TxStart : TxIdle;
         default: tx_st_d = TxIdle;
      endcase
   end

   assign tx_pop = (tx_st_d == TxStart) && (tx_st_q != TxStart);

   always_comb begin
      tx_line = 1'b1;
      case (tx_st_q)
         TxStart: tx_line = 1'b0;
         TxData:  tx_line = tx_sh_q[0];
         TxPar:   tx_line = tx_par_q;
         default: tx_line = 1'b1;
      endcase
   end

   assign tx_o = loop_i ? 1'b1 : tx_line;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_pen_q   <= 1'b0;
         tx_stop2_q <= 1'b0;
      end else begin
         if (tx_st_q == TxIdle) tx_cnt_q <= '0;
         else if (tick)         tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + OW'(1);
         if (tx_st_d != tx_st_q) tx_bit_q <= '0;
         else if (tx_bit_end)    tx_bit_q <= tx_bit_q + BW'(1);
         if (tx_pop) begin
            tx_sh_q    <= tx_head;
            tx_par_q   <= (^tx_head) ^ (parity_i == 2'b01);
            tx_pen_q   <= (parity_i == 2'b01) || (parity_i == 2'b10);
            tx_stop2_q <= stop2_i;
         end else if (tx_st_q == TxData && tx_bit_end) begin
            tx_sh_q <= tx_sh_q >> 1;
         end
      end
   end

   assign rx_in      = loop_i ? tx_line : rx_i;
   assign rx_fall    = rx_prev_q && !rx_s_q;
   assign rx_bit_end = tick && (rx_cnt_q == OvsLast);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_s1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= RxIdle;
      end else begin
         rx_s1_q   <= rx_in;
         rx_s_q    <= rx_s1_q;
         rx_prev_q <= rx_s_q;
         rx_st_q   <= rx_st_d;
      end
   end

   // A framing error parks in RxWait until the line returns high.
   always_comb begin
      rx_st_d = rx_st_q;
      case (rx_st_q)
         RxIdle:  if (rx_fall) rx_st_d = RxStart;
         RxStart: if (tick && rx_cnt_q == OvsMid) rx_st_d = rx_s_q ? RxIdle : RxData;
         RxData:  if (rx_bit_end && rx_bit_q == BitLast)
                     rx_st_d = (parity_i == 2'b01 || parity_i == 2'b10) ? RxPar : RxStop;
         RxPar:   if (rx_bit_end) rx_st_d = RxStop;
         RxStop:  if (rx_bit_end) rx_st_d = rx_s_q ? RxIdle : RxWait;
         RxWait:  if (rx_s_q) rx_st_d = RxIdle;
         default: rx_st_d = RxIdle;
      endcase
   end

   always_comb begin
      rx_push = (rx_st_q == RxStop) && rx_bit_end;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_perr_q <= 1'b0;
      end else begin
         if (rx_st_d != rx_st_q)           rx_cnt_q <= '0;
         else if (tick && rx_st_q != RxIdle) rx_cnt_q <= (rx_cnt_q == OvsLast) ? '0 : rx_cnt_q + OW'(1);
         if (rx_st_d != rx_st_q) rx_bit_q <= '0;
         else if (rx_bit_end)    rx_bit_q <= rx_bit_q + BW'(1);
         if (rx_st_q == RxData && rx_bit_end) rx_sh_q <= {rx_s_q, rx_sh_q[DATA_W-1:1]};
         if (rx_st_q == RxStart) rx_perr_q <= 1'b0;
         else if (rx_st_q == RxPar && rx_bit_end)
            rx_perr_q <= rx_s_q ^ (^rx_sh_q) ^ (parity_i == 2'b01);
      end
   end

   assign rx_level_o = rx_wp_q - rx_rp_q;
   assign rx_valid_o = (rx_level_o != '0);
   assign rx_full    = (rx_level_o == Full);
   assign rx_pop     = rx_valid_o && rx_ready_i;
   assign rx_wr      = rx_push && (!rx_full || rx_pop);
   assign rx_head    = rx_valid_o ? rx_mem[rx_rp_q[AW-1:0]] : '0;
   assign {rx_perr_o, rx_ferr_o, rx_data_o} = rx_head;
   assign rx_ovf_o   = rx_ovf_q;

   always_ff @(posedge clk_i) begin
      if (rx_wr) rx_mem[rx_wp_q[AW-1:0]] <= {rx_perr_q, ~rx_s_q, rx_sh_q};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_ovf_q <= 1'b0;
      end else begin
         if (rx_wr)  rx_wp_q <= rx_wp_q + LW'(1);
         if (rx_pop) rx_rp_q <= rx_rp_q + LW'(1);
         if (rx_push && !rx_wr) rx_ovf_q <= 1'b1;
         else if (ovf_clr_i)    rx_ovf_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: reset, loopback stream, TX framing, RX errors,
// glitch rejection, overrun and mid-frame reset.
module tb_uart_core;
   localparam int unsigned DW = 8;
   localparam int unsigned FD = 16;
   localparam int unsigned OV = 16;
   localparam int unsigned LW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [15:0]   div_i;
   logic [1:0]    parity_i;
   logic          stop2_i, loop_i;
   logic [DW-1:0] tx_data_i;
   logic          tx_valid_i, tx_ready_o;
   logic [DW-1:0] rx_data_o;
   logic          rx_perr_o, rx_ferr_o, rx_valid_o, rx_ready_i;
   logic          rx_ovf_o, ovf_clr_i, tx_busy_o;
   logic [LW-1:0] tx_level_o, rx_level_o;
   logic          tx_o, rx_i;

   uart_core #(.DATA_W(DW), .FIFO_DEPTH(FD), .OVS(OV)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .parity_i(parity_i),
      .stop2_i(stop2_i), .loop_i(loop_i), .tx_data_i(tx_data_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
      .rx_perr_o(rx_perr_o), .rx_ferr_o(rx_ferr_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .rx_ovf_o(rx_ovf_o), .ovf_clr_i(ovf_clr_i),
      .tx_busy_o(tx_busy_o), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
      .tx_o(tx_o), .rx_i(rx_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_rx(input int budget, output logic ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk_i);
         if (rx_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_rx();
      rx_ready_i = 1'b1;
      @(negedge clk_i);
      rx_ready_i = 1'b0;
   endtask

   task automatic write_tx(input logic [7:0] d);
      tx_data_i  = d;
      tx_valid_i = 1'b1;
      @(negedge clk_i);
      tx_valid_i = 1'b0;
   endtask

   // Bit i of f goes out i-th; assumes div_i=0 so one bit is OV clocks.
   task automatic drive_frame(input logic [15:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         rx_i = f[i];
         repeat (OV) @(negedge clk_i);
      end
      rx_i = 1'b1;
   endtask

   task automatic wait_tx_fall();
      for (int n = 0; n < 300 && tx_o; n++) @(negedge clk_i);
   endtask

   initial begin
      logic [7:0]  exp_q [50];
      logic [11:0] t3_bits;
      logic        ok;
      int          last;
      int          lows;

      rst_i = 1'b1; div_i = '0; parity_i = 2'b00; stop2_i = 1'b0; loop_i = 1'b0;
      tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b0; ovf_clr_i = 1'b0; rx_i = 1'b1;
      last = 0;
      lows = 0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_tx_o", 32'(tx_o), 1);
      check_eq("rst_tx_ready", 32'(tx_ready_o), 1);
      check_eq("rst_rx_valid", 32'(rx_valid_o), 0);
      check_eq("rst_tx_busy", 32'(tx_busy_o), 0);
      check_eq("rst_ovf", 32'(rx_ovf_o), 0);
      check_eq("rst_levels", 32'({tx_level_o, rx_level_o}), 0);
      check_eq("rst_rx_head", 32'({rx_data_o, rx_perr_o, rx_ferr_o}), 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Loopback 8N1 at div 0: 50 random bytes, back-to-back 160-clock frames.
      loop_i = 1'b1;
      for (int i = 0; i < 50; i++) exp_q[i] = 8'($urandom);
      fork
         begin
            for (int i = 0; i < 50; i++) begin
               for (int n = 0; n < 400 && !tx_ready_o; n++) @(negedge clk_i);
               write_tx(exp_q[i]);
            end
         end
         begin
            for (int k = 0; k < 50; k++) begin
               wait_rx(600, ok);
               check_eq("lb_timeout", 32'(ok), 1);
               check_eq("lb_data", 32'(rx_data_o), 32'(exp_q[k]));
               check_eq("lb_err", 32'({rx_perr_o, rx_ferr_o}), 0);
               if (k > 0) check_eq("lb_gap", cyc - last, 160);
               last = cyc;
               pop_rx();
            end
         end
      join
      repeat (40) @(negedge clk_i);
      loop_i = 1'b0;

      // External line, div 3, even parity, two stop bits, 0x07: 64 clocks per bit.
      div_i = 16'd3; parity_i = 2'b10; stop2_i = 1'b1;
      repeat (8) @(negedge clk_i);
      t3_bits = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
      write_tx(8'h07);
      wait_tx_fall();
      check_eq("t3_start_seen", 32'(tx_o), 0);
      for (int i = 0; i < 12; i++) begin
         check_eq("t3_bit_head", 32'(tx_o), 32'(t3_bits[i]));
         repeat (63) @(negedge clk_i);
         check_eq("t3_bit_tail", 32'(tx_o), 32'(t3_bits[i]));
         @(negedge clk_i);
      end
      check_eq("t3_idle", 32'(tx_o), 1);
      check_eq("t3_busy", 32'(tx_busy_o), 0);

      // RX: odd parity, 0x55 with wrong parity and stop 0, then a clean 0xA3.
      div_i = '0; parity_i = 2'b01; stop2_i = 1'b0;
      repeat (8) @(negedge clk_i);
      drive_frame(16'({1'b0, 1'b0, 8'h55, 1'b0}), 11);
      repeat (32) @(negedge clk_i);
      wait_rx(100, ok);
      check_eq("t4_timeout", 32'(ok), 1);
      check_eq("t4_bad_entry", 32'({rx_data_o, rx_perr_o, rx_ferr_o}), 32'({8'h55, 2'b11}));
      pop_rx();
      check_eq("t4_empty", 32'(rx_valid_o), 0);
      drive_frame(16'({1'b1, 1'b1, 8'hA3, 1'b0}), 11);
      repeat (16) @(negedge clk_i);
      wait_rx(100, ok);
      check_eq("t4_good_timeout", 32'(ok), 1);
      check_eq("t4_good_entry", 32'({rx_data_o, rx_perr_o, rx_ferr_o}), 32'({8'hA3, 2'b00}));
      pop_rx();

      // Glitch: 4 ticks low is rejected at the start-bit midpoint.
      parity_i = 2'b00;
      rx_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (64) @(negedge clk_i);
      check_eq("t5_no_push", 32'({rx_valid_o, rx_level_o}), 0);
      drive_frame(16'({1'b1, 8'h3C, 1'b0}), 10);
      repeat (16) @(negedge clk_i);
      wait_rx(100, ok);
      check_eq("t5_after_timeout", 32'(ok), 1);
      check_eq("t5_after_entry", 32'({rx_data_o, rx_perr_o, rx_ferr_o}), 32'({8'h3C, 2'b00}));
      pop_rx();

      // Overrun: 17 frames with no pops.
      for (int k = 0; k < 17; k++) drive_frame(16'({1'b1, 8'(k * 7 + 1), 1'b0}), 10);
      repeat (16) @(negedge clk_i);
      check_eq("t6_level", 32'(rx_level_o), 16);
      check_eq("t6_ovf", 32'(rx_ovf_o), 1);
      check_eq("t6_tx_ready", 32'(tx_ready_o), 1);
      for (int k = 0; k < 16; k++) begin
         check_eq("t6_data", 32'(rx_data_o), 32'(8'(k * 7 + 1)));
         pop_rx();
      end
      check_eq("t6_drained", 32'(rx_valid_o), 0);
      check_eq("t6_ovf_sticky", 32'(rx_ovf_o), 1);
      ovf_clr_i = 1'b1;
      @(negedge clk_i);
      ovf_clr_i = 1'b0;
      check_eq("t6_ovf_clr", 32'(rx_ovf_o), 0);

      // Reset in the middle of DATA with 3 bytes queued.
      for (int k = 0; k < 4; k++) write_tx(8'h00);
      wait_tx_fall();
      repeat (40) @(negedge clk_i);
      check_eq("t7_in_data", 32'(tx_o), 0);
      check_eq("t7_queued", 32'(tx_level_o), 3);
      #2 rst_i = 1'b1;
      #1;
      check_eq("t7_async_tx_o", 32'(tx_o), 1);
      check_eq("t7_level", 32'(tx_level_o), 0);
      check_eq("t7_busy", 32'(tx_busy_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk_i);
         if (!tx_o) lows++;
      end
      check_eq("t7_quiet", lows, 0);
      check_eq("t7_level_after", 32'(tx_level_o), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
